// File: rtl/alarm_sequencer.sv
// ============================================================================
// Module   : alarm_sequencer
// Purpose  : Matches watch time against the alarm setting and sequences the
//            buzzer (beep cadence, snooze, stop, ring timeout). Optional
//            feature macro: ALARM_SEQ_AUTO_SNOOZE_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alarm_sequencer #(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZE     = 3,
  parameter int BEEP_ON_S      = 1,
  parameter int BEEP_OFF_S     = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick_sec,
  input  logic       bud_en,
  input  logic       snooze_i,
  input  logic       stop_i,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] minone_now,
  input  logic [3:0] hourdec_bud,
  input  logic [3:0] hourone_bud,
  input  logic [3:0] mindec_bud,
  input  logic [3:0] minone_bud,
  output logic       aud_en,
  output logic       bud_state,
  output logic [3:0] snooze_cnt
);

  localparam int c_SEC_MAX  = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
  localparam int c_SEC_W    = $clog2(c_SEC_MAX + 1);
  localparam int c_BEEP_MAX = (BEEP_ON_S > BEEP_OFF_S) ? BEEP_ON_S : BEEP_OFF_S;
  localparam int c_PH_W     = $clog2(c_BEEP_MAX + 1);

  // Terminal values are the count reached on the tick before the event fires.
  localparam logic [c_SEC_W-1:0] c_RING_LAST = c_SEC_W'(RING_TIMEOUT_S - 1);
  localparam logic [c_SEC_W-1:0] c_SNZ_LAST  = c_SEC_W'(SNOOZE_S - 1);
  localparam logic [c_PH_W-1:0]  c_ON_LAST   = c_PH_W'(BEEP_ON_S - 1);
  localparam logic [c_PH_W-1:0]  c_OFF_LAST  = c_PH_W'(BEEP_OFF_S - 1);
  localparam logic [3:0]         c_MAX_SNZ   = 4'(MAX_SNOOZE);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_RING   = 3'd2,
    ST_SNOOZE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_match_q;
  logic [c_SEC_W-1:0] r_sec_cnt;
  logic [c_PH_W-1:0]  r_ph_cnt;
  logic               r_phase_on;
  logic               r_aud_en;
  logic               r_bud_state;
  logic [3:0]         r_snooze_cnt;

  logic w_match;
  logic w_hit;
  logic w_snz_left;

  assign w_match    = ({hourdec_now, hourone_now, mindec_now, minone_now} ==
                       {hourdec_bud, hourone_bud, mindec_bud, minone_bud});
  assign w_hit      = w_match & ~r_match_q;
  assign w_snz_left = (r_snooze_cnt < c_MAX_SNZ);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_match_q    <= 1'b0;
      r_sec_cnt    <= '0;
      r_ph_cnt     <= '0;
      r_phase_on   <= 1'b0;
      r_aud_en     <= 1'b0;
      r_bud_state  <= 1'b0;
      r_snooze_cnt <= '0;
    end else begin
      r_match_q <= w_match;
      if (!bud_en) begin
        r_state      <= ST_IDLE;
        r_sec_cnt    <= '0;
        r_ph_cnt     <= '0;
        r_phase_on   <= 1'b0;
        r_aud_en     <= 1'b0;
        r_bud_state  <= 1'b0;
        r_snooze_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_ARMED;

          ST_ARMED: begin
            if (w_hit) begin
              r_state      <= ST_RING;
              r_sec_cnt    <= '0;
              r_ph_cnt     <= '0;
              r_phase_on   <= 1'b1;
              r_aud_en     <= 1'b1;
              r_bud_state  <= 1'b1;
              r_snooze_cnt <= '0;
            end
          end

          ST_RING: begin
            // Buttons take precedence; a coincident tick is dropped.
            if (stop_i || (snooze_i && !w_snz_left)) begin
              r_state     <= ST_DONE;
              r_aud_en    <= 1'b0;
              r_bud_state <= 1'b0;
            end else if (snooze_i) begin
              r_state      <= ST_SNOOZE;
              r_aud_en     <= 1'b0;
              r_sec_cnt    <= '0;
              r_snooze_cnt <= r_snooze_cnt + 4'd1;
            end else if (tick_sec) begin
              if (r_sec_cnt == c_RING_LAST) begin
`ifdef ALARM_SEQ_AUTO_SNOOZE_EN
                r_aud_en <= 1'b0;
                if (w_snz_left) begin
                  r_state      <= ST_SNOOZE;
                  r_sec_cnt    <= '0;
                  r_snooze_cnt <= r_snooze_cnt + 4'd1;
                end else begin
                  r_state     <= ST_DONE;
                  r_bud_state <= 1'b0;
                end
`else
                r_state     <= ST_DONE;
                r_aud_en    <= 1'b0;
                r_bud_state <= 1'b0;
`endif
              end else begin
                r_sec_cnt <= r_sec_cnt + c_SEC_W'(1);
                if (r_phase_on) begin
                  if (r_ph_cnt == c_ON_LAST) begin
                    r_phase_on <= 1'b0;
                    r_ph_cnt   <= '0;
                    r_aud_en   <= 1'b0;
                  end else begin
                    r_ph_cnt <= r_ph_cnt + c_PH_W'(1);
                  end
                end else begin
                  if (r_ph_cnt == c_OFF_LAST) begin
                    r_phase_on <= 1'b1;
                    r_ph_cnt   <= '0;
                    r_aud_en   <= 1'b1;
                  end else begin
                    r_ph_cnt <= r_ph_cnt + c_PH_W'(1);
                  end
                end
              end
            end
          end

          ST_SNOOZE: begin
            if (stop_i) begin
              r_state     <= ST_DONE;
              r_aud_en    <= 1'b0;
              r_bud_state <= 1'b0;
            end else if (tick_sec) begin
              if (r_sec_cnt == c_SNZ_LAST) begin
                r_state    <= ST_RING;
                r_sec_cnt  <= '0;
                r_ph_cnt   <= '0;
                r_phase_on <= 1'b1;
                r_aud_en   <= 1'b1;
              end else begin
                r_sec_cnt <= r_sec_cnt + c_SEC_W'(1);
              end
            end
          end

          // Hold off until the alarm minute has passed to avoid retriggering.
          ST_DONE: begin
            if (!w_match) r_state <= ST_ARMED;
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign aud_en     = r_aud_en;
  assign bud_state  = r_bud_state;
  assign snooze_cnt = r_snooze_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alarm_sequencer.sv
// ============================================================================
// Module   : tb_alarm_sequencer
// Purpose  : Directed self-checking bench for alarm_sequencer (alarm 07:30,
//            timeout 4 s, snooze 5 s, two snoozes, 1/1 beep cadence).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alarm_sequencer;

  logic       clk;
  logic       rstn;
  logic       tick_sec;
  logic       bud_en;
  logic       snooze_i;
  logic       stop_i;
  logic [3:0] hourdec_now, hourone_now, mindec_now, minone_now;
  logic [3:0] hourdec_bud, hourone_bud, mindec_bud, minone_bud;
  logic       aud_en;
  logic       bud_state;
  logic [3:0] snooze_cnt;

  int n_checks = 0;
  int n_err    = 0;

  alarm_sequencer #(
    .RING_TIMEOUT_S(4),
    .SNOOZE_S      (5),
    .MAX_SNOOZE    (2),
    .BEEP_ON_S     (1),
    .BEEP_OFF_S    (1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .tick_sec   (tick_sec),
    .bud_en     (bud_en),
    .snooze_i   (snooze_i),
    .stop_i     (stop_i),
    .hourdec_now(hourdec_now),
    .hourone_now(hourone_now),
    .mindec_now (mindec_now),
    .minone_now (minone_now),
    .hourdec_bud(hourdec_bud),
    .hourone_bud(hourone_bud),
    .mindec_bud (mindec_bud),
    .minone_bud (minone_bud),
    .aud_en     (aud_en),
    .bud_state  (bud_state),
    .snooze_cnt (snooze_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_min(input logic [3:0] m1, input logic [3:0] m0);
    mindec_now = m1;
    minone_now = m0;
  endtask

  task automatic tick();
    tick_sec = 1'b1;
    step();
    tick_sec = 1'b0;
    step();
  endtask

  task automatic pulse(input logic snz, input logic stp);
    snooze_i = snz;
    stop_i   = stp;
    step();
    snooze_i = 1'b0;
    stop_i   = 1'b0;
  endtask

  // Leave the alarm minute, then enter it again to produce a fresh hit.
  task automatic ring_up();
    set_min(4'd3, 4'd1);
    step();
    step();
    set_min(4'd3, 4'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; tick_sec = 1'b0; bud_en = 1'b0; snooze_i = 1'b0; stop_i = 1'b0;
    hourdec_now = 4'd0; hourone_now = 4'd7; mindec_now = 4'd2; minone_now = 4'd9;
    hourdec_bud = 4'd0; hourone_bud = 4'd7; mindec_bud = 4'd3; minone_bud = 4'd0;
    step(); step();
    check("rst_aud_en", {3'b0, aud_en}, 4'd0);
    check("rst_bud_state", {3'b0, bud_state}, 4'd0);
    check("rst_snooze_cnt", snooze_cnt, 4'd0);

    // Arm at 07:29, then roll into 07:30.
    rstn = 1'b1; step();
    bud_en = 1'b1; step(); step();
    set_min(4'd3, 4'd0);
    #1;
    check("pre_edge_aud_en", {3'b0, aud_en}, 4'd0);
    step();
    check("hit_aud_en", {3'b0, aud_en}, 4'd1);
    check("hit_bud_state", {3'b0, bud_state}, 4'd1);
    tick();
    check("beep_off", {3'b0, aud_en}, 4'd0);
    tick();
    check("beep_on", {3'b0, aud_en}, 4'd1);

    pulse(1'b0, 1'b1);
    check("stop_aud_en", {3'b0, aud_en}, 4'd0);
    check("stop_bud_state", {3'b0, bud_state}, 4'd0);
    step(); step(); step();
    check("no_rering_bud_state", {3'b0, bud_state}, 4'd0);
    check("no_rering_aud_en", {3'b0, aud_en}, 4'd0);
    ring_up();
    check("rearm_ring", {3'b0, aud_en}, 4'd1);

    // Snooze: exactly five ticks until ringing resumes.
    pulse(1'b1, 1'b0);
    check("snz1_aud_en", {3'b0, aud_en}, 4'd0);
    check("snz1_bud_state", {3'b0, bud_state}, 4'd1);
    check("snz1_cnt", snooze_cnt, 4'd1);
    pulse(1'b1, 1'b0);
    check("snz_ignored_cnt", snooze_cnt, 4'd1);
    for (int i = 0; i < 4; i++) tick();
    check("snz_4ticks_aud_en", {3'b0, aud_en}, 4'd0);
    check("snz_4ticks_bud_state", {3'b0, bud_state}, 4'd1);
    tick();
    check("snz_5ticks_aud_en", {3'b0, aud_en}, 4'd1);

    pulse(1'b1, 1'b0);
    check("snz2_cnt", snooze_cnt, 4'd2);
    for (int i = 0; i < 5; i++) tick();
    check("snz2_rering", {3'b0, aud_en}, 4'd1);
    pulse(1'b1, 1'b0);
    check("snz3_done_bud_state", {3'b0, bud_state}, 4'd0);
    check("snz3_done_aud_en", {3'b0, aud_en}, 4'd0);
    check("snz3_cnt_held", snooze_cnt, 4'd2);

    // New event clears the snooze count; stop beats snooze.
    ring_up();
    check("new_event_cnt", snooze_cnt, 4'd0);
    check("new_event_aud_en", {3'b0, aud_en}, 4'd1);
    pulse(1'b1, 1'b1);
    check("stop_snz_bud_state", {3'b0, bud_state}, 4'd0);
    check("stop_snz_cnt", snooze_cnt, 4'd0);

    // Ring timeout with no buttons.
    ring_up();
    tick();
    check("to_t1_aud_en", {3'b0, aud_en}, 4'd0);
    tick();
    check("to_t2_aud_en", {3'b0, aud_en}, 4'd1);
    tick();
    check("to_t3_bud_state", {3'b0, bud_state}, 4'd1);
    tick();
    check("to_aud_en", {3'b0, aud_en}, 4'd0);
`ifdef ALARM_SEQ_AUTO_SNOOZE_EN
    check("to_bud_state", {3'b0, bud_state}, 4'd1);
    check("to_cnt", snooze_cnt, 4'd1);
`else
    check("to_bud_state", {3'b0, bud_state}, 4'd0);
    check("to_cnt", snooze_cnt, 4'd0);
`endif
    pulse(1'b0, 1'b1);

    // Disarm mid-ring.
    ring_up();
    check("disarm_pre_aud_en", {3'b0, aud_en}, 4'd1);
    bud_en = 1'b0;
    step();
    check("disarm_aud_en", {3'b0, aud_en}, 4'd0);
    check("disarm_bud_state", {3'b0, bud_state}, 4'd0);

    // Arming inside the matching minute must not ring.
    bud_en = 1'b1;
    step(); step(); step();
    check("arm_in_match_aud_en", {3'b0, aud_en}, 4'd0);
    check("arm_in_match_bud_state", {3'b0, bud_state}, 4'd0);

    // Asynchronous reset mid-ring.
    ring_up();
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_aud_en", {3'b0, aud_en}, 4'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_aud_en", {3'b0, aud_en}, 4'd0);
    check("async_rst_bud_state", {3'b0, bud_state}, 4'd0);
    check("async_rst_cnt", snooze_cnt, 4'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
